// File: rtl/cmsdk_ahb_decoder_defslave.sv
// ---------------------------------------------------------------------------
// cmsdk_ahb_decoder_defslave
//
// AHB-Lite address decoder with an integrated default slave and an
// error-capture register. HADDR is decoded into one-hot region selects
// (HSEL0..HSEL3) plus HSELDEF for unmapped space. The default slave answers
// every active, accepted transfer to unmapped space with a two-cycle ERROR
// response and logs the offending address and a saturating error count.
//
// Ports
//   HCLK          in   clock, rising edge
//   HRESETn       in   synchronous active-low reset
//   HADDR[31:0]   in   address-phase address
//   HTRANS[1:0]   in   transfer type (bit 1 = NONSEQ/SEQ)
//   HREADY        in   bus ready from the slave mux
//   ERRCLR        in   synchronous clear of ERRADDR/ERRCNT
//   HSEL0..HSEL3  out  region selects (lowest index wins on overlap)
//   HSELDEF       out  default-slave select (no region matched)
//   HREADYOUTDEF  out  default-slave ready
//   HRESPDEF      out  default-slave response, 1 = ERROR
//   HRDATADEF     out  default-slave read data, always zero
//   ERRADDR[31:0] out  address of the last logged error
//   ERRCNT[7:0]   out  saturating count of logged errors
//   ERRIRQ        out  one-cycle pulse per logged error
//   dbg_state     out  default-slave FSM state (0 IDLE, 1 ERR1, 2 ERR2)
// ---------------------------------------------------------------------------
module cmsdk_ahb_decoder_defslave #(
  parameter logic [31:0] REGION0_BASE = 32'h0000_0000,
  parameter logic [31:0] REGION0_MASK = 32'hE000_0000,
  parameter logic [31:0] REGION1_BASE = 32'h2000_0000,
  parameter logic [31:0] REGION1_MASK = 32'hE000_0000,
  parameter logic [31:0] REGION2_BASE = 32'h4000_0000,
  parameter logic [31:0] REGION2_MASK = 32'hF000_0000,
  parameter logic [31:0] REGION3_BASE = 32'hE000_0000,
  parameter logic [31:0] REGION3_MASK = 32'hF000_0000,
  parameter int          DW           = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HREADY,
  input  logic          ERRCLR,
  output logic          HSEL0,
  output logic          HSEL1,
  output logic          HSEL2,
  output logic          HSEL3,
  output logic          HSELDEF,
  output logic          HREADYOUTDEF,
  output logic          HRESPDEF,
  output logic [DW-1:0] HRDATADEF,
  output logic [31:0]   ERRADDR,
  output logic [7:0]    ERRCNT,
  output logic          ERRIRQ,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0] match;
  logic       errxfer;

  // Only HTRANS[1] distinguishes active from IDLE/BUSY transfers.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // ---------------- Address decode (combinational, HADDR only) -------------
  assign match[0] = (HADDR & REGION0_MASK) == REGION0_BASE;
  assign match[1] = (HADDR & REGION1_MASK) == REGION1_BASE;
  assign match[2] = (HADDR & REGION2_MASK) == REGION2_BASE;
  assign match[3] = (HADDR & REGION3_MASK) == REGION3_BASE;

  // Priority chain keeps the selects one-hot when regions overlap.
  assign HSEL0   = match[0];
  assign HSEL1   = match[1] & ~match[0];
  assign HSEL2   = match[2] & ~|match[1:0];
  assign HSEL3   = match[3] & ~|match[2:0];
  assign HSELDEF = ~|match;

  // Handshake: a transfer is accepted when HREADY is high at the end of its
  // address phase; only accepted active transfers to unmapped space count.
  assign errxfer = HSELDEF & HREADY & HTRANS[1];

  // ---------------- Default-slave FSM ---------------------------------------
  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    HREADYOUTDEF = 1'b1;
    HRESPDEF     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (errxfer) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        HREADYOUTDEF = 1'b0;
        HRESPDEF     = 1'b1;
        state_nxt    = ST_ERR2;
      end
      ST_ERR2: begin
        HRESPDEF  = 1'b1;
        // The next address phase overlaps ERR2, so a back-to-back error
        // goes straight into its own wait state.
        state_nxt = errxfer ? ST_ERR1 : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dbg_state = state;
  assign HRDATADEF = '0;

  // ---------------- Error capture -------------------------------------------
  // A simultaneous clear and error logs the new error on top of a fresh
  // count, so ERRCNT becomes 1 rather than 0.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ERRADDR <= 32'h0;
      ERRCNT  <= 8'h00;
      ERRIRQ  <= 1'b0;
    end else if (errxfer) begin
      ERRADDR <= HADDR;
      if (ERRCLR)              ERRCNT <= 8'h01;
      else if (ERRCNT != 8'hFF) ERRCNT <= ERRCNT + 8'h01;
      ERRIRQ  <= 1'b1;
    end else begin
      if (ERRCLR) begin
        ERRADDR <= 32'h0;
        ERRCNT  <= 8'h00;
      end
      ERRIRQ <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmsdk_ahb_decoder_defslave.sv
// ---------------------------------------------------------------------------
// tb_cmsdk_ahb_decoder_defslave
//
// Directed bench for the decoder/default slave. The bench plays the role of
// the slave mux: it drives HREADY low while the default slave is in its wait
// state. A second instance with overlapping regions checks select priority.
// ---------------------------------------------------------------------------
module tb_cmsdk_ahb_decoder_defslave;

  // ---------------- Clock / reset -------------------------------------------
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        ERRCLR;

  always #5 HCLK = ~HCLK;

  // ---------------- DUT (default regions) -----------------------------------
  logic        HSEL0, HSEL1, HSEL2, HSEL3, HSELDEF;
  logic        HREADYOUTDEF, HRESPDEF, ERRIRQ;
  logic [31:0] HRDATADEF, ERRADDR;
  logic [7:0]  ERRCNT;
  logic [1:0]  dbg_state;

  cmsdk_ahb_decoder_defslave u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .ERRCLR(ERRCLR),
    .HSEL0(HSEL0), .HSEL1(HSEL1), .HSEL2(HSEL2), .HSEL3(HSEL3),
    .HSELDEF(HSELDEF), .HREADYOUTDEF(HREADYOUTDEF), .HRESPDEF(HRESPDEF),
    .HRDATADEF(HRDATADEF), .ERRADDR(ERRADDR), .ERRCNT(ERRCNT),
    .ERRIRQ(ERRIRQ), .dbg_state(dbg_state)
  );

  // ---------------- DUT (overlapping regions: 1 shadows 0, 3 shadows 2) -----
  logic        o_sel0, o_sel1, o_sel2, o_sel3, o_seldef;
  logic        o_ready, o_resp, o_irq;
  logic [31:0] o_rdata, o_erraddr;
  logic [7:0]  o_errcnt;
  logic [1:0]  o_state;

  cmsdk_ahb_decoder_defslave #(
    .REGION1_BASE(32'h0000_0000), .REGION1_MASK(32'hE000_0000),
    .REGION3_BASE(32'h4000_0000), .REGION3_MASK(32'hF000_0000)
  ) u_ovl (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .ERRCLR(ERRCLR),
    .HSEL0(o_sel0), .HSEL1(o_sel1), .HSEL2(o_sel2), .HSEL3(o_sel3),
    .HSELDEF(o_seldef), .HREADYOUTDEF(o_ready), .HRESPDEF(o_resp),
    .HRDATADEF(o_rdata), .ERRADDR(o_erraddr), .ERRCNT(o_errcnt),
    .ERRIRQ(o_irq), .dbg_state(o_state)
  );

  // ---------------- Checker and driver tasks --------------------------------
  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1 ns after the rising edge.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans,
                       input logic rdy);
    HADDR  = addr;
    HTRANS = trans;
    HREADY = rdy;
    #1;
  endtask

  function automatic logic [4:0] sels();
    return {HSEL0, HSEL1, HSEL2, HSEL3, HSELDEF};
  endfunction

  // Combined response view: {state, HREADYOUTDEF, HRESPDEF, ERRIRQ}
  function automatic logic [4:0] rsp();
    return {dbg_state, HREADYOUTDEF, HRESPDEF, ERRIRQ};
  endfunction

  // ---------------- Directed sequence ---------------------------------------
  initial begin
    HRESETn = 1'b0;
    ERRCLR  = 1'b0;
    drive(32'h2000_0010, 2'b00, 1'b1);
    step();
    step();

    // Reset state and decode
    chk("rst_sel_2000_0010", 32'(sels()), 32'b01000);
    chk("rst_rsp",           32'(rsp()),  {27'd0, 2'd0, 1'b1, 1'b0, 1'b0});
    chk("rst_errcnt",        32'(ERRCNT), 32'd0);
    chk("rst_erraddr",       ERRADDR,     32'h0);
    chk("rdata_zero",        HRDATADEF,   32'h0);
    drive(32'h6000_0000, 2'b00, 1'b1);
    chk("sel_6000_0000",     32'(sels()), 32'b00001);
    drive(32'h1FFF_FFFC, 2'b00, 1'b1);
    chk("sel_1fff_fffc",     32'(sels()), 32'b10000);
    drive(32'h4123_0000, 2'b00, 1'b1);
    chk("sel_4123_0000",     32'(sels()), 32'b00100);
    drive(32'h5000_0000, 2'b00, 1'b1);
    chk("sel_5000_0000",     32'(sels()), 32'b00001);
    drive(32'hE000_1000, 2'b00, 1'b1);
    chk("sel_e000_1000",     32'(sels()), 32'b00010);
    drive(32'hF000_0000, 2'b00, 1'b1);
    chk("sel_f000_0000",     32'(sels()), 32'b00001);

    HRESETn = 1'b1;
    step();

    // Single NONSEQ to unmapped space
    drive(32'h6000_0004, 2'b10, 1'b1);
    step();
    drive(32'h0000_0000, 2'b00, 1'b0);            // mux ready low in ERR1
    chk("single_err1_rsp",   32'(rsp()),  {27'd0, 2'd1, 1'b0, 1'b1, 1'b1});
    chk("single_erraddr",    ERRADDR,     32'h6000_0004);
    chk("single_errcnt",     32'(ERRCNT), 32'd1);
    step();
    drive(32'h0000_0000, 2'b00, 1'b1);
    chk("single_err2_rsp",   32'(rsp()),  {27'd0, 2'd2, 1'b1, 1'b1, 1'b0});
    step();
    chk("single_idle_rsp",   32'(rsp()),  {27'd0, 2'd0, 1'b1, 1'b0, 1'b0});

    // ERRCLR alone
    ERRCLR = 1'b1;
    step();
    ERRCLR = 1'b0;
    chk("clr_errcnt",        32'(ERRCNT), 32'd0);
    chk("clr_erraddr",       ERRADDR,     32'h0);

    // Back-to-back errors: second address phase during ERR2
    drive(32'h6000_0100, 2'b10, 1'b1);
    step();
    drive(32'h6000_0100, 2'b10, 1'b0);            // address held in wait state
    chk("b2b_a_err1",        32'(rsp()),  {27'd0, 2'd1, 1'b0, 1'b1, 1'b1});
    step();
    drive(32'h7000_0000, 2'b10, 1'b1);
    chk("b2b_a_err2",        32'(rsp()),  {27'd0, 2'd2, 1'b1, 1'b1, 1'b0});
    step();
    drive(32'h0000_0000, 2'b00, 1'b0);
    chk("b2b_b_err1",        32'(rsp()),  {27'd0, 2'd1, 1'b0, 1'b1, 1'b1});
    chk("b2b_errcnt",        32'(ERRCNT), 32'd2);
    chk("b2b_erraddr",       ERRADDR,     32'h7000_0000);
    step();
    drive(32'h0000_0000, 2'b00, 1'b1);
    chk("b2b_b_err2",        32'(rsp()),  {27'd0, 2'd2, 1'b1, 1'b1, 1'b0});
    step();
    chk("b2b_idle",          32'(rsp()),  {27'd0, 2'd0, 1'b1, 1'b0, 1'b0});

    // Non-logged transfers: IDLE, BUSY, NONSEQ with HREADY low, mapped NONSEQ
    drive(32'h6000_0000, 2'b00, 1'b1);
    step();
    chk("idle_xfer_rsp",     32'(rsp()),  {27'd0, 2'd0, 1'b1, 1'b0, 1'b0});
    drive(32'h6000_0000, 2'b01, 1'b1);
    step();
    chk("busy_xfer_rsp",     32'(rsp()),  {27'd0, 2'd0, 1'b1, 1'b0, 1'b0});
    drive(32'h6000_0000, 2'b10, 1'b0);
    step();
    chk("nrdy_xfer_rsp",     32'(rsp()),  {27'd0, 2'd0, 1'b1, 1'b0, 1'b0});
    drive(32'h2000_0000, 2'b10, 1'b1);
    step();
    chk("mapped_xfer_rsp",   32'(rsp()),  {27'd0, 2'd0, 1'b1, 1'b0, 1'b0});
    chk("nolog_errcnt",      32'(ERRCNT), 32'd2);
    chk("nolog_erraddr",     ERRADDR,     32'h7000_0000);

    // 300 back-to-back errors saturate the counter
    for (int i = 0; i < 300; i++) begin
      drive(32'h8000_0000 + 32'(i * 4), 2'b10, 1'b1);
      step();
      drive(32'h0000_0000, 2'b00, 1'b0);
      step();
    end
    chk("sat_errcnt",        32'(ERRCNT), 32'hFF);
    chk("sat_erraddr",       ERRADDR,     32'h8000_04AC);
    chk("sat_in_err2",       32'(dbg_state), 32'd2);

    // ERRCLR together with an error transfer (accepted in ERR2)
    ERRCLR = 1'b1;
    drive(32'h9000_0000, 2'b10, 1'b1);
    step();
    ERRCLR = 1'b0;
    drive(32'h0000_0000, 2'b00, 1'b0);
    chk("clrerr_errcnt",     32'(ERRCNT), 32'd1);
    chk("clrerr_erraddr",    ERRADDR,     32'h9000_0000);
    chk("clrerr_rsp",        32'(rsp()),  {27'd0, 2'd1, 1'b0, 1'b1, 1'b1});
    step();
    drive(32'h0000_0000, 2'b00, 1'b1);
    step();
    ERRCLR = 1'b1;
    step();
    ERRCLR = 1'b0;
    chk("clr2_errcnt",       32'(ERRCNT), 32'd0);
    chk("clr2_erraddr",      ERRADDR,     32'h0);

    // Reset asserted during ERR1
    drive(32'hA000_0000, 2'b10, 1'b1);
    step();
    drive(32'h0000_0000, 2'b00, 1'b0);
    chk("prerst_err1",       32'(dbg_state), 32'd1);
    chk("prerst_errcnt",     32'(ERRCNT), 32'd1);
    HRESETn = 1'b0;
    step();
    chk("midrst_rsp",        32'(rsp()),  {27'd0, 2'd0, 1'b1, 1'b0, 1'b0});
    chk("midrst_errcnt",     32'(ERRCNT), 32'd0);
    chk("midrst_erraddr",    ERRADDR,     32'h0);
    HRESETn = 1'b1;
    drive(32'h0000_0000, 2'b00, 1'b1);
    step();

    // Overlapping regions: lower index wins
    drive(32'h1000_0000, 2'b00, 1'b1);
    chk("ovl_sel_1000_0000",
        32'({o_sel0, o_sel1, o_sel2, o_sel3, o_seldef}), 32'b10000);
    drive(32'h4000_0040, 2'b00, 1'b1);
    chk("ovl_sel_4000_0040",
        32'({o_sel0, o_sel1, o_sel2, o_sel3, o_seldef}), 32'b00100);
    drive(32'hE000_0000, 2'b00, 1'b1);
    chk("ovl_sel_e000_0000",
        32'({o_sel0, o_sel1, o_sel2, o_sel3, o_seldef}), 32'b00001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog: the directed sequence is bounded, this only guards a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmsdk_ahb_decoder_defslave.md
# cmsdk_ahb_decoder_defslave

AHB-Lite address decoder with an integrated default slave and an error-capture register. Sits directly upstream of the slave multiplexer. It decodes HADDR into one-hot HSEL0..HSEL3 plus HSELDEF, drives those selects into mux ports 0..4, and supplies the port-4 response signals (HREADYOUTDEF, HRESPDEF, HRDATADEF). Any active transfer to an unmapped address gets a two-cycle AHB ERROR response, and its address and a running count are logged.

## Interface
- REGION0_BASE, 32'h0000_0000, base address matched for HSEL0
- REGION0_MASK, 32'hE000_0000, compare mask for HSEL0
- REGION1_BASE, 32'h2000_0000, base for HSEL1
- REGION1_MASK, 32'hE000_0000, mask for HSEL1
- REGION2_BASE, 32'h4000_0000, base for HSEL2
- REGION2_MASK, 32'hF000_0000, mask for HSEL2
- REGION3_BASE, 32'hE000_0000, base for HSEL3
- REGION3_MASK, 32'hF000_0000, mask for HSEL3
- DW, 32, read data width
- HCLK  in  1  clock; all state updates on the rising edge
- HRESETn  in  1  reset; synchronous, active-low
- HADDR  in  32  address-phase address
- HTRANS  in  2  transfer type; bit 1 set means NONSEQ or SEQ
- HREADY  in  1  bus ready, taken from the mux HREADYOUT
- ERRCLR  in  1  synchronous clear of ERRADDR and ERRCNT
- HSEL0..HSEL3  out  1 each  region selects
- HSELDEF  out  1  default-slave select (no region matched)
- HREADYOUTDEF  out  1  default-slave ready
- HRESPDEF  out  1  default-slave response; 1 = ERROR
- HRDATADEF  out  DW  constant zero
- ERRADDR  out  32  address of the last unmapped active transfer
- ERRCNT  out  8  saturating count of unmapped active transfers
- ERRIRQ  out  1  one-cycle pulse per logged error

## Operation
- Decode is combinational from HADDR only; HTRANS and HREADY are not used.
- Region n matches when (HADDR & REGIONn_MASK) == REGIONn_BASE.
- On overlapping regions the lowest index wins, so exactly one of HSEL0..3/HSELDEF is high at all times.
- HSELDEF = no region matched.
- Accepted error transfer ("errxfer"): HSELDEF & HREADY & HTRANS[1].
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE: HREADYOUTDEF=1, HRESPDEF=0. Goes to ERR1 on errxfer, otherwise stays.
  - ERR1: HREADYOUTDEF=0, HRESPDEF=1. Always goes to ERR2.
  - ERR2: HREADYOUTDEF=1, HRESPDEF=1. Goes to ERR1 on errxfer (back-to-back error), otherwise IDLE.
- IDLE and BUSY transfers, or any transfer with HREADY low, get an OKAY zero-wait response and are not logged.
- Error logging on errxfer:
  - ERRADDR <= HADDR.
  - ERRCNT <= ERRCNT+1, saturating at 8'hFF.
  - ERRIRQ high for the next cycle.
- ERRCLR alone sets ERRADDR=0 and ERRCNT=0.
- ERRCLR and errxfer in the same cycle: ERRADDR=HADDR, ERRCNT=1, ERRIRQ pulses.
- HRDATADEF is always zero.

## Timing
- Reset values (HRESETn low at a rising edge):
  - FSM=IDLE, HREADYOUTDEF=1, HRESPDEF=0
  - ERRADDR=0, ERRCNT=0, ERRIRQ=0
- HSEL* have no reset state; they follow HADDR.
- Reset takes effect only at a clock edge. Asserting it mid-error (ERR1 or ERR2) returns to IDLE at that edge, and no response phase completes.
- Error response latency:
  - Address phase at edge N.
  - Cycle N+1: ERR1 (wait state, HRESP=1).
  - Cycle N+2: ERR2 (HREADY=1, HRESP=1).
- ERRADDR, ERRCNT and ERRIRQ update at edge N, so they are visible during cycle N+1.
- In ERR1 the bus HREADY is low, so no new errxfer can be accepted. The next error's address phase can only coincide with ERR2.
- Back-to-back errors: ERR1, ERR2, ERR1, ERR2, with no IDLE cycle between them and ERRIRQ pulsing once per error.

## Test plan
- Reset with defaults: HADDR=32'h2000_0010 -> HSEL1=1 and all other selects 0; HADDR=32'h6000_0000 -> HSELDEF=1; HREADYOUTDEF=1, HRESPDEF=0, ERRCNT=0.
- Single NONSEQ to 32'h6000_0004 with HREADY=1:
  - next cycle: HREADYOUTDEF=0, HRESPDEF=1, ERRADDR=32'h6000_0004, ERRCNT=1, ERRIRQ=1
  - following cycle: HREADYOUTDEF=1, HRESPDEF=1
  - then IDLE/OKAY
- Two consecutive unmapped NONSEQs (second address phase in ERR2) -> FSM sequence ERR1, ERR2, ERR1, ERR2; ERRCNT=2; ERRADDR equals the second address; two ERRIRQ pulses.
- IDLE transfer (HTRANS=2'b00) to an unmapped address, and a NONSEQ with HREADY=0 -> HREADYOUTDEF stays 1, HRESPDEF stays 0, ERRCNT unchanged.
- 300 unmapped errors -> ERRCNT=8'hFF; ERRCLR with a simultaneous errxfer -> ERRCNT=1; ERRCLR alone -> ERRCNT=0, ERRADDR=0.
- HRESETn low during ERR1 -> HREADYOUTDEF=1, HRESPDEF=0 and ERRCNT=0 after that edge; overlapping-region parameter set -> the lower index is selected.
